// File: rtl/sar_controller.sv
// sar_controller: successive-approximation sequencer for the SAR ADC core.
// Tracks the input for SAMPLE_CYCLES cycles and then runs an N-bit binary search
// (N = 12/14/16). Each trial holds sar_data for SETTLE_CYCLES cycles and reads
// comp_out on the last edge of the trial. The result is published for one DONE cycle.
module sar_controller #(
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  resolution,
    input  logic        comp_out,
    output logic        sample_en,
    output logic        dac_enable,
    output logic [15:0] sar_data,
    output logic        busy,
    output logic [15:0] data_out,
    output logic        data_valid
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;     // cycles spent in the current phase / bit trial
    logic [3:0]  bit_q, bit_d;     // bit under trial; holds N-1 while sampling
    logic [15:0] code_q, code_d;   // trial code driven to the DAC
    logic [15:0] data_q, data_d;   // last completed result
    logic [15:0] decided;          // trial code with the bit under test resolved

    // Current trial code with the bit under test replaced by the comparator decision
    always_comb begin
        decided          = code_q;
        decided[bit_q]   = comp_out;
    end

    // Next-state and datapath updates of the sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        code_d  = code_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                // abort is deliberately ignored here, even together with start
                if (start) begin
                    state_d = S_SAMPLE;
                    cnt_d   = 8'd0;
                    code_d  = 16'd0;
                    case (resolution)
                        2'b00:   bit_d = 4'd11;
                        2'b01:   bit_d = 4'd13;
                        default: bit_d = 4'd15;
                    endcase
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    code_d  = 16'd0;
                end else if (cnt_q == SAMPLE_LAST) begin
                    state_d = S_CONVERT;
                    cnt_d   = 8'd0;
                    code_d  = 16'd1 << bit_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CONVERT: begin
                // abort has priority over the final bit decision
                if (abort) begin
                    state_d = S_IDLE;
                    code_d  = 16'd0;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d = 8'd0;
                    if (bit_q != 4'd0) begin
                        code_d = decided | (16'd1 << (bit_q - 4'd1));
                        bit_d  = bit_q - 4'd1;
                    end else begin
                        data_d  = decided;
                        code_d  = 16'd0;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                // DONE lasts one cycle; start seen here is dropped
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            code_q  <= 16'd0;
            data_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            code_q  <= code_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them immediately
    always_comb begin
        sample_en  = (state_q == S_SAMPLE);
        busy       = (state_q == S_SAMPLE) || (state_q == S_CONVERT);
        dac_enable = busy;
        data_valid = (state_q == S_DONE);
        sar_data   = code_q;
        data_out   = data_q;
    end

endmodule
